rom_burst_fetch: RTL and testbench

- Synchronous, parametrised instruction ROM with a valid/ready fetch interface and burst reads.
- Sits between the fetch stage and the boot image. Accepts one request (start address, beat count) and streams consecutive instruction words with backpressure.
- The image lookup lives in a combinational sub-module. This block adds a registered output, address sequencing, wrap-around, out-of-range flagging and handshakes.

---
 rtl/rom_pkg.sv | 27 ++
 rtl/rom_image.sv | 32 +++
 rtl/rom_burst_fetch.sv | 122 ++++++++++++
 tb/tb_rom_burst_fetch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared definitions for the burst-fetch instruction ROM: default widths,
// FSM state encoding and the boot image word constants.
package rom_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 8;
    localparam int LEN_W_DEF  = 4;
    localparam int DEPTH_DEF  = 256;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam logic [15:0] IMG_BASE = 16'hC000;
    localparam logic [15:0] IMG_08   = 16'h2908;
    localparam logic [15:0] IMG_09   = 16'h689C;
    localparam logic [15:0] IMG_FILL = 16'hC000;
    localparam logic [15:0] IMG_FF   = 16'h9800;

    // Words 0x00..0x07 form a ramp: the opcode field steps by 0x0800 and the
    // low byte carries the word index.
    function automatic logic [15:0] img_ramp(input logic [2:0] idx);
        return IMG_BASE + {2'b00, idx, 11'h000} + {13'h0000, idx};
    endfunction

endpackage

// File: rtl/rom_image.sv
// Combinational boot-image lookup; unlisted addresses read as zero and every
// entry is zero-extended to DATA_W.
module rom_image
    import rom_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic [15:0] word;

    always_comb begin
        word = 16'h0000;
        if (addr < ADDR_W'(8)) begin
            word = img_ramp(addr[2:0]);
        end else if (addr == ADDR_W'(8)) begin
            word = IMG_08;
        end else if (addr == ADDR_W'(9)) begin
            word = IMG_09;
        end else if (addr < ADDR_W'(16)) begin
            word = IMG_FILL;
        end else if (addr == ADDR_W'(255)) begin
            word = IMG_FF;
        end
    end

    assign data = DATA_W'(word);

endmodule

// File: rtl/rom_burst_fetch.sv
// Burst instruction fetch from the boot image: one request streams req_len+1
// consecutive words through a registered valid/ready output stage.
module rom_burst_fetch
    import rom_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_last,
    output logic              rsp_err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_last_q, rsp_last_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept;
    logic              load;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] img_data;
    logic              beat_err;

    // The output register may refill whenever it is empty or draining this edge.
    assign req_ready = (state_q == ST_IDLE) && (!rsp_valid_q || rsp_ready) && rst_n;
    assign accept    = req_valid && req_ready;
    assign load      = (state_q == ST_BURST) && (!rsp_valid_q || rsp_ready);
    assign beat_addr = accept ? req_addr : next_addr_q;
    assign beat_err  = {1'b0, beat_addr} >= DEPTH_L;

    rom_image #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_image (
        .addr(beat_addr),
        .data(img_data)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        next_addr_d = next_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;

        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_addr_d  = req_addr;
            rsp_data_d  = beat_err ? '0 : img_data;
            rsp_err_d   = beat_err;
            rsp_last_d  = (req_len == '0);
            if (req_len != '0) begin
                remaining_d = req_len;
                next_addr_d = req_addr + ADDR_W'(1);
                state_d     = ST_BURST;
            end
        end else if (load) begin
            rsp_valid_d = 1'b1;
            rsp_addr_d  = next_addr_q;
            rsp_data_d  = beat_err ? '0 : img_data;
            rsp_err_d   = beat_err;
            rsp_last_d  = (remaining_q == LEN_W'(1));
            remaining_d = remaining_q - LEN_W'(1);
            next_addr_d = next_addr_q + ADDR_W'(1);
            if (remaining_q == LEN_W'(1)) begin
                state_d = ST_IDLE;
            end
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            next_addr_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            next_addr_q <= next_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rom_burst_fetch.sv
// Cycle-level check of rom_burst_fetch (full-depth and DEPTH=16 instances)
// against a queue-based reference of the burst protocol.
module tb_rom_burst_fetch;

    localparam int DW = 64;
    localparam int AW = 8;
    localparam int LW = 4;
    localparam int DEPTH_A = 256;
    localparam int DEPTH_B = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          rsp_ready;

    logic          a_req_ready, a_rsp_valid, a_rsp_last, a_rsp_err;
    logic [DW-1:0] a_rsp_data;
    logic [AW-1:0] a_rsp_addr;
    logic          b_req_ready, b_rsp_valid, b_rsp_last, b_rsp_err;
    logic [DW-1:0] b_rsp_data;
    logic [AW-1:0] b_rsp_addr;

    always #5 clk = ~clk;

    rom_burst_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_A), .LEN_W(LW)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(a_req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(a_rsp_data), .rsp_addr(a_rsp_addr),
        .rsp_last(a_rsp_last), .rsp_err(a_rsp_err)
    );

    rom_burst_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_B), .LEN_W(LW)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(b_req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(b_rsp_data), .rsp_addr(b_rsp_addr),
        .rsp_last(b_rsp_last), .rsp_err(b_rsp_err)
    );

    // Reference: the beat on the output plus a queue of addresses still owed.
    logic [AW-1:0] pend_q[$];
    logic          m_valid;
    logic          m_last;
    logic [AW-1:0] m_addr;
    logic          m_rst;
    logic          m_accepted;

    int errors = 0;
    int checks = 0;

    function automatic logic [DW-1:0] img(input logic [AW-1:0] a);
        case (a)
            8'h00: return 64'hC000;
            8'h01: return 64'hC801;
            8'h02: return 64'hD002;
            8'h03: return 64'hD803;
            8'h04: return 64'hE004;
            8'h05: return 64'hE805;
            8'h06: return 64'hF006;
            8'h07: return 64'hF807;
            8'h08: return 64'h2908;
            8'h09: return 64'h689C;
            8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F: return 64'hC000;
            8'hFF: return 64'h9800;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic exp_err(input logic [AW-1:0] a, input int depth);
        return !m_rst && (int'(a) >= depth);
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input int depth);
        if (m_rst || int'(a) >= depth) return '0;
        return img(a);
    endfunction

    function automatic logic model_ready();
        return rst_n && (pend_q.size() == 0) && (!m_valid || rsp_ready);
    endfunction

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic          can_take;
        logic [AW-1:0] a;
        m_accepted = 1'b0;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_addr  = '0;
            m_rst   = 1'b1;
            pend_q.delete();
        end else begin
            can_take = !m_valid || rsp_ready;
            if (pend_q.size() == 0 && can_take && req_valid) begin
                m_accepted = 1'b1;
                m_valid    = 1'b1;
                m_rst      = 1'b0;
                m_addr     = req_addr;
                for (int i = 1; i <= int'(req_len); i++) begin
                    a = req_addr + AW'(i);
                    pend_q.push_back(a);
                end
                m_last = (pend_q.size() == 0);
                $display("req addr=%h len=%0d accepted t=%0t", req_addr, req_len, $time);
            end else if (pend_q.size() != 0 && can_take) begin
                m_valid = 1'b1;
                m_rst   = 1'b0;
                m_addr  = pend_q.pop_front();
                m_last  = (pend_q.size() == 0);
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Inputs are already driven; check outputs, advance one edge, return at negedge.
    task automatic tick();
        #1;
        check_eq("a_req_ready", 64'(a_req_ready), 64'(model_ready()));
        check_eq("b_req_ready", 64'(b_req_ready), 64'(model_ready()));
        check_eq("a_rsp_valid", 64'(a_rsp_valid), 64'(m_valid));
        check_eq("b_rsp_valid", 64'(b_rsp_valid), 64'(m_valid));
        check_eq("a_rsp_addr",  64'(a_rsp_addr),  64'(m_addr));
        check_eq("b_rsp_addr",  64'(b_rsp_addr),  64'(m_addr));
        check_eq("a_rsp_last",  64'(a_rsp_last),  64'(m_last));
        check_eq("b_rsp_last",  64'(b_rsp_last),  64'(m_last));
        check_eq("a_rsp_data",  a_rsp_data, exp_data(m_addr, DEPTH_A));
        check_eq("b_rsp_data",  b_rsp_data, exp_data(m_addr, DEPTH_B));
        check_eq("a_rsp_err",   64'(a_rsp_err), 64'(exp_err(m_addr, DEPTH_A)));
        check_eq("b_rsp_err",   64'(b_rsp_err), 64'(exp_err(m_addr, DEPTH_B)));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] l);
        bit done = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        for (int n = 0; n < 40 && !done; n++) begin
            tick();
            done = m_accepted;
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=not_accepted exp=accepted addr=%h", a);
        end
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while ((m_valid || pend_q.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=busy exp=idle");
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        rsp_ready = 1'b1;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_addr    = '0;
        m_rst     = 1'b1;
        m_accepted = 1'b0;
        @(posedge clk);
        @(negedge clk);

        repeat (3) tick();
        rst_n = 1'b1;
        send(8'h01, 4'd0);
        drain();

        send(8'h06, 4'd3);
        drain();

        send(8'h06, 4'd3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        tick();
        drain();

        send(8'hFE, 4'd2);
        drain();
        send(8'h0E, 4'd2);
        drain();

        send(8'h20, 4'd7);
        rsp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();

        send(8'h03, 4'd1);
        rsp_ready = 1'b1;
        tick();
        send(8'h08, 4'd2);
        drain();

        repeat (400) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            req_valid = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0: req_addr = AW'($urandom_range(0, 255));
                1: req_addr = AW'($urandom_range(0, 17));
                2: req_addr = AW'($urandom_range(248, 255));
                default: req_addr = AW'($urandom_range(12, 18));
            endcase
            req_len   = LW'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst_n = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
